nx_ia_mem_arb: RTL and testbench
================================

NX_IA_MEM_ARB -- requirements
Module: nx_ia_mem_arb

Interface
REQ-001 Parameters SHALL be N_ADDR_BITS (default 9; memory address width), N_DATA_BITS (default 96; data width), MAX_HW_BURST (default 8; 1..15; consecutive HW wins allowed while SW waits) and RD_LAT (default 1; 1..3; memory read latency in cycles).
REQ-002 Ports SHALL be, in order: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-003 hw_req_cs, hw_req_we in 1 each; hw_req_add in N_ADDR_BITS; hw_req_wdat in N_DATA_BITS: datapath access request.
REQ-004 hw_stall out 1 (HW request not taken this cycle); hw_rdat_vld out 1; hw_rdat out N_DATA_BITS.
REQ-005 sw_cs, sw_we in 1 each; sw_add in N_ADDR_BITS; sw_wdat in N_DATA_BITS; sw_yield in 1; sw_reset in 1: indirect-access controller port.
REQ-006 grant out 1 (SW access issued this cycle); sw_rdat out N_DATA_BITS.
REQ-007 mem_cs, mem_we out 1 each; mem_add out N_ADDR_BITS; mem_wdat out N_DATA_BITS; mem_rdat in N_DATA_BITS: single-port memory.
REQ-008 stall_cnt out 16 (saturating count of HW-stalled cycles); starve_seen out 1 (sticky: sw_yield observed high).

Function
REQ-009 The winner SHALL be decided combinationally each cycle: SW wins if sw_cs && (sw_reset || sw_yield || burst_cnt == MAX_HW_BURST || !hw_req_cs); otherwise HW wins if hw_req_cs; otherwise no access.
REQ-010 grant SHALL be high exactly in cycles where SW wins; hw_stall SHALL equal hw_req_cs && !HW-wins.
REQ-011 mem_cs/mem_we/mem_add/mem_wdat SHALL be a combinational mux of the winner's signals; mem_cs = 0 and mem_we = 0 when no access.
REQ-012 burst_cnt (4-bit register) SHALL increment on a HW win with sw_cs high, clear on any SW win or when sw_cs is low, and saturate at MAX_HW_BURST.
REQ-013 A tag shift register of depth RD_LAT SHALL carry {valid, owner} for each issued read (mem_cs && !mem_we); writes SHALL carry no tag.
REQ-014 When a HW tag exits, hw_rdat_vld SHALL pulse 1 cycle with hw_rdat = mem_rdat that cycle; hw_rdat SHALL otherwise hold.
REQ-015 When a SW tag exits, sw_rdat SHALL be loaded from mem_rdat; with RD_LAT = 1, sw_rdat SHALL equal mem_rdat combinationally in the exit cycle and be held thereafter.
REQ-016 State machine ARB_IDLE/ARB_HW/ARB_SW (registered last winner) SHALL reflect the previous cycle's owner; ARB_HW to ARB_SW when SW wins; ARB_SW to ARB_HW when HW wins; any to ARB_IDLE on no access.
REQ-017 While sw_reset is high and sw_cs is high, HW SHALL be stalled every cycle (init/reset sweep owns the memory).
REQ-018 stall_cnt SHALL increment by 1 per hw_stall cycle and hold at 16'hFFFF.
REQ-019 starve_seen SHALL set on sw_yield high and clear only on reset.
REQ-020 hw_req_cs and sw_cs simultaneous with burst_cnt < MAX_HW_BURST and no yield/reset SHALL give HW the win.

Reset
REQ-021 On rst_n low, state SHALL be ARB_IDLE; burst_cnt, tag pipeline, stall_cnt, starve_seen, hw_rdat_vld SHALL be 0; hw_rdat and sw_rdat SHALL be 0.
REQ-022 Reads in flight at reset assertion SHALL be discarded; no rdat_vld SHALL be produced after reset deassertion for them.
REQ-023 grant and mem_cs SHALL be 0 while rst_n is low, regardless of inputs.

Structure
REQ-024 Owner enum (OWN_HW, OWN_SW) and the arbiter state enum SHALL live in the shared nx_mem_typePKG.
REQ-025 The read tag pipeline SHALL be a sub-module nx_ia_rd_tag_pipe (parameter RD_LAT).

Verification
REQ-026 HW only, 4 reads at addr 0..3, RD_LAT=1 -> mem_cs 4 cycles, hw_rdat_vld 4 cycles each 1 cycle later, grant never high.
REQ-027 SW write only at addr 9'h1A0 -> grant=1 same cycle, mem_we=1, mem_add=9'h1A0, hw_stall=0.
REQ-028 HW continuous, SW read pending, MAX_HW_BURST=8 -> 8 HW wins, then grant on cycle 9 with hw_stall=1, stall_cnt=1.
REQ-029 HW continuous, sw_yield=1 with sw_cs -> grant same cycle, starve_seen=1 and remains 1 after sw_yield drops.
REQ-030 sw_reset=1 with sw_cs for 512 cycles while HW requests -> grant 512 cycles, hw_stall 512 cycles, stall_cnt=512.
REQ-031 rst_n low one cycle after HW read issue -> no hw_rdat_vld after reset, all outputs at reset values.

Source files
------------

// File: rtl/nx_ia_mem_arb_pkg.sv
// Shared types for the indirect-access memory arbiter: the access owner, the
// arbiter state and the read tag that travels alongside each memory read.
`default_nettype none

package nx_mem_typePKG;

  typedef enum logic {
    OWN_HW = 1'b0,
    OWN_SW = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HW   = 2'd1,
    ARB_SW   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } rd_tag_t;

  localparam int unsigned STALL_CNT_W  = 16;
  localparam int unsigned BURST_CNT_W  = 4;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [BURST_CNT_W-1:0] sat_inc_burst(
    input logic [BURST_CNT_W-1:0] val,
    input logic [BURST_CNT_W-1:0] lim
  );
    return (val >= lim) ? lim : val + BURST_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nx_ia_mem_arb_rd_tag_pipe.sv
// Read tag delay line: one {valid, owner} tag per cycle, emerging RD_LAT
// cycles later so returning memory data can be steered to its requester.
`default_nettype none

module nx_ia_rd_tag_pipe
  import nx_mem_typePKG::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_q [RD_LAT];
  rd_tag_t pipe_d [RD_LAT];

  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Asynchronous clear drops every read in flight at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/nx_ia_mem_arb.sv
// Single-port memory arbiter between the datapath (HW) and an indirect-access
// controller (SW), with bounded HW bursts, SW yield/reset override and read steering.
`default_nettype none

module nx_ia_mem_arb
  import nx_mem_typePKG::*;
#(
  parameter int unsigned N_ADDR_BITS  = 9,
  parameter int unsigned N_DATA_BITS  = 96,
  parameter int unsigned MAX_HW_BURST = 8,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hw_req_cs,
  input  logic                   hw_req_we,
  input  logic [N_ADDR_BITS-1:0] hw_req_add,
  input  logic [N_DATA_BITS-1:0] hw_req_wdat,
  output logic                   hw_stall,
  output logic                   hw_rdat_vld,
  output logic [N_DATA_BITS-1:0] hw_rdat,
  input  logic                   sw_cs,
  input  logic                   sw_we,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  input  logic                   sw_yield,
  input  logic                   sw_reset,
  output logic                   grant,
  output logic [N_DATA_BITS-1:0] sw_rdat,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [N_ADDR_BITS-1:0] mem_add,
  output logic [N_DATA_BITS-1:0] mem_wdat,
  input  logic [N_DATA_BITS-1:0] mem_rdat,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   starve_seen
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(MAX_HW_BURST);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  arb_state_e             state_q,       state_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q,   burst_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
  logic                   starve_seen_q, starve_seen_d;
  logic [N_DATA_BITS-1:0] hw_rdat_q,     hw_rdat_d;
  logic [N_DATA_BITS-1:0] sw_rdat_q,     sw_rdat_d;

  logic    sw_win;
  logic    hw_win;
  logic    hw_exit;
  logic    sw_exit;
  rd_tag_t issue_tag;
  rd_tag_t exit_tag;

  // Winner selection; rst_n gating keeps the memory idle while reset is held.
  always_comb begin
    sw_win = rst_n && sw_cs &&
             (sw_reset || sw_yield || (burst_cnt_q == BURST_LIM) || !hw_req_cs);
    hw_win = rst_n && hw_req_cs && !sw_win;
  end

  always_comb begin
    mem_cs   = sw_win || hw_win;
    mem_we   = 1'b0;
    mem_add  = hw_req_add;
    mem_wdat = hw_req_wdat;
    if (sw_win) begin
      mem_we   = sw_we;
      mem_add  = sw_add;
      mem_wdat = sw_wdat;
    end else if (hw_win) begin
      mem_we   = hw_req_we;
    end
  end

  always_comb begin
    issue_tag.vld   = mem_cs && !mem_we;
    issue_tag.owner = sw_win ? OWN_SW : OWN_HW;
  end

  nx_ia_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (issue_tag),
    .tag_out (exit_tag)
  );

  // Returning data is forwarded in its exit cycle and captured for holding.
  always_comb begin
    hw_exit   = exit_tag.vld && (exit_tag.owner == OWN_HW);
    sw_exit   = exit_tag.vld && (exit_tag.owner == OWN_SW);
    hw_rdat_d = hw_exit ? mem_rdat : hw_rdat_q;
    sw_rdat_d = sw_exit ? mem_rdat : sw_rdat_q;
  end

  // The burst counter only runs while SW is waiting behind HW.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (hw_win && sw_cs) begin
      burst_cnt_d = sat_inc_burst(burst_cnt_q, BURST_LIM);
    end else if (sw_win || !sw_cs) begin
      burst_cnt_d = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hw_stall && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
    starve_seen_d = starve_seen_q || sw_yield;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (sw_win)      state_d = ARB_SW;
        else if (hw_win) state_d = ARB_HW;
      end
      ARB_HW: begin
        if (sw_win)       state_d = ARB_SW;
        else if (!hw_win) state_d = ARB_IDLE;
      end
      ARB_SW: begin
        if (hw_win)       state_d = ARB_HW;
        else if (!sw_win) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      burst_cnt_q   <= '0;
      stall_cnt_q   <= '0;
      starve_seen_q <= 1'b0;
      hw_rdat_q     <= '0;
      sw_rdat_q     <= '0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      starve_seen_q <= starve_seen_d;
      hw_rdat_q     <= hw_rdat_d;
      sw_rdat_q     <= sw_rdat_d;
    end
  end

  assign grant       = sw_win;
  assign hw_stall    = hw_req_cs && !hw_win;
  assign hw_rdat_vld = hw_exit;
  assign hw_rdat     = hw_rdat_d;
  assign sw_rdat     = sw_rdat_d;
  assign stall_cnt   = stall_cnt_q;
  assign starve_seen = starve_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_nx_ia_mem_arb.sv
// Self-checking bench for nx_ia_mem_arb: vector table, directed corner
// sequences and a randomized run against a cycle-level behavioural model.
`default_nettype none

module tb_nx_ia_mem_arb;

  localparam int AW   = 9;
  localparam int DW   = 96;
  localparam int MAXB = 8;
  localparam int LAT  = 1;

  logic          clk;
  logic          rst_n;
  logic          hw_req_cs, hw_req_we;
  logic [AW-1:0] hw_req_add;
  logic [DW-1:0] hw_req_wdat;
  logic          hw_stall, hw_rdat_vld;
  logic [DW-1:0] hw_rdat;
  logic          sw_cs, sw_we, sw_yield, sw_reset;
  logic [AW-1:0] sw_add;
  logic [DW-1:0] sw_wdat;
  logic          grant;
  logic [DW-1:0] sw_rdat;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] mem_rdat;
  logic [15:0]   stall_cnt;
  logic          starve_seen;

  nx_ia_mem_arb #(
    .N_ADDR_BITS (AW), .N_DATA_BITS (DW), .MAX_HW_BURST (MAXB), .RD_LAT (LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .hw_req_cs (hw_req_cs), .hw_req_we (hw_req_we), .hw_req_add (hw_req_add),
    .hw_req_wdat (hw_req_wdat), .hw_stall (hw_stall), .hw_rdat_vld (hw_rdat_vld),
    .hw_rdat (hw_rdat), .sw_cs (sw_cs), .sw_we (sw_we), .sw_add (sw_add),
    .sw_wdat (sw_wdat), .sw_yield (sw_yield), .sw_reset (sw_reset), .grant (grant),
    .sw_rdat (sw_rdat), .mem_cs (mem_cs), .mem_we (mem_we), .mem_add (mem_add),
    .mem_wdat (mem_wdat), .mem_rdat (mem_rdat), .stall_cnt (stall_cnt),
    .starve_seen (starve_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT: synchronous, one-cycle read latency.
  logic          mem_init;
  logic [DW-1:0] tb_mem [512];

  function automatic logic [DW-1:0] init_word(input int i);
    return {32'(i) * 32'h9E3779B1, 32'(i) ^ 32'hA5A50000, 32'(i) + 32'h12345678};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) tb_mem[i] <= init_word(i);
    end else if (mem_cs) begin
      if (mem_we) tb_mem[mem_add] <= mem_wdat;
      else        mem_rdat <= tb_mem[mem_add];
    end
  end

  // Reference model state.
  typedef struct {
    bit            vld;
    bit            sw;
    logic [DW-1:0] data;
  } rd_t;

  typedef struct {
    bit            hcs, hwe;
    logic [AW-1:0] hadd;
    logic [DW-1:0] hwd;
    bit            scs, swe;
    logic [AW-1:0] sadd;
    logic [DW-1:0] swd;
    bit            syld, srst;
  } stim_t;

  typedef struct {
    bit            hcs, hwe, scs, swe, syld, srst;
    logic [AW-1:0] hadd, sadd;
    bit            e_grant, e_stall, e_cs, e_we;
    logic [AW-1:0] e_add;
  } vec_t;

  rd_t           pipe[$];
  logic [DW-1:0] shadow [512];
  int            m_burst, m_stall;
  bit            m_starve;
  logic [DW-1:0] m_hw_rdat, m_sw_rdat;
  bit            m_sw_won;

  int            n_cmp, n_err;
  bit            s_grant, s_stall, s_cs, s_we, s_vld, s_starve;
  logic [AW-1:0] s_add;
  logic [15:0]   s_stall_cnt;
  int            cnt_grant, cnt_stall, cnt_vld, cnt_cs;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_burst   = 0;
    m_stall   = 0;
    m_starve  = 0;
    m_hw_rdat = '0;
    m_sw_rdat = '0;
    m_sw_won  = 0;
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back('{vld: 0, sw: 0, data: '0});
  endtask

  function automatic stim_t mk(input bit hcs, input bit hwe, input logic [AW-1:0] hadd,
                               input bit scs, input bit swe, input logic [AW-1:0] sadd,
                               input bit syld, input bit srst);
    stim_t s;
    s.hcs = hcs; s.hwe = hwe; s.hadd = hadd; s.hwd = {$urandom, $urandom, $urandom};
    s.scs = scs; s.swe = swe; s.sadd = sadd; s.swd = {$urandom, $urandom, $urandom};
    s.syld = syld; s.srst = srst;
    return s;
  endfunction

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input stim_t s);
    bit            sw_w, hw_w, acc, we, exp_hv;
    logic [AW-1:0] add;
    logic [DW-1:0] wd, exp_hr, exp_sr;
    rd_t           ex, nw;
    @(negedge clk);
    hw_req_cs = s.hcs; hw_req_we = s.hwe; hw_req_add = s.hadd; hw_req_wdat = s.hwd;
    sw_cs = s.scs; sw_we = s.swe; sw_add = s.sadd; sw_wdat = s.swd;
    sw_yield = s.syld; sw_reset = s.srst;
    #1;
    sw_w   = s.scs && (s.srst || s.syld || m_burst == MAXB || !s.hcs);
    hw_w   = !sw_w && s.hcs;
    acc    = sw_w || hw_w;
    we     = sw_w ? s.swe : (hw_w ? s.hwe : 1'b0);
    add    = sw_w ? s.sadd : s.hadd;
    wd     = sw_w ? s.swd : s.hwd;
    ex     = pipe[$];
    exp_hv = ex.vld && !ex.sw;
    exp_hr = exp_hv ? ex.data : m_hw_rdat;
    exp_sr = (ex.vld && ex.sw) ? ex.data : m_sw_rdat;

    check("grant", grant, sw_w);
    check("hw_stall", hw_stall, s.hcs && !hw_w);
    check("mem_cs", mem_cs, acc);
    check("mem_we", mem_we, we);
    if (acc) check("mem_add", mem_add, add);
    if (acc && we) check("mem_wdat", mem_wdat, wd);
    check("hw_rdat_vld", hw_rdat_vld, exp_hv);
    check("hw_rdat", hw_rdat, exp_hr);
    check("sw_rdat", sw_rdat, exp_sr);
    check("stall_cnt", stall_cnt, 16'(m_stall));
    check("starve_seen", starve_seen, m_starve);

    s_grant = grant; s_stall = hw_stall; s_cs = mem_cs; s_we = mem_we; s_add = mem_add;
    s_vld = hw_rdat_vld; s_starve = starve_seen; s_stall_cnt = stall_cnt;
    cnt_grant += int'(grant); cnt_stall += int'(hw_stall);
    cnt_vld += int'(hw_rdat_vld); cnt_cs += int'(mem_cs);

    m_hw_rdat = exp_hr;
    m_sw_rdat = exp_sr;
    m_sw_won  = sw_w;
    if (hw_w && s.scs)        m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
    else if (sw_w || !s.scs)  m_burst = 0;
    if (s.hcs && !hw_w && m_stall < 65535) m_stall++;
    if (s.syld) m_starve = 1;
    nw = '{vld: 0, sw: 0, data: '0};
    if (acc) begin
      if (we) shadow[add] = wd;
      else    nw = '{vld: 1, sw: sw_w, data: shadow[add]};
    end
    pipe.push_front(nw);
    void'(pipe.pop_back());
  endtask

  task automatic idle();
    step(mk(0, 0, '0, 0, 0, '0, 0, 0));
  endtask

  task automatic zero_inputs();
    hw_req_cs = 0; hw_req_we = 0; hw_req_add = '0; hw_req_wdat = '0;
    sw_cs = 0; sw_we = 0; sw_add = '0; sw_wdat = '0; sw_yield = 0; sw_reset = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_hw_rdat_vld", hw_rdat_vld, 0);
    check("rst_hw_rdat", hw_rdat, 0);
    check("rst_sw_rdat", sw_rdat, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_starve_seen", starve_seen, 0);
    rst_n = 1'b1;
    model_reset();
    cnt_grant = 0; cnt_stall = 0; cnt_vld = 0; cnt_cs = 0;
  endtask

  vec_t vt[10];

  initial begin
    int     first_grant;
    bit     stall_at_grant;
    bit     sw_pend;
    stim_t  st;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    mem_init = 1'b1;
    zero_inputs();
    for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
    model_reset();
    repeat (3) @(negedge clk);
    mem_init = 1'b0;

    // HW-only reads at 0..3: each returns one cycle later, SW never granted.
    do_reset();
    for (int i = 0; i < 4; i++) step(mk(1, 0, 9'(i), 0, 0, '0, 0, 0));
    repeat (2) idle();
    check("hw_only_cs_cycles", cnt_cs, 4);
    check("hw_only_vld_cycles", cnt_vld, 4);
    check("hw_only_grant_cycles", cnt_grant, 0);

    // Pending SW read behind continuous HW: granted on the ninth cycle.
    do_reset();
    first_grant = 0; stall_at_grant = 0;
    for (int i = 1; i <= 10; i++) begin
      step(mk(1, 0, 9'(i), 1, 0, 9'h005, 0, 0));
      if (s_grant && first_grant == 0) begin
        first_grant = i;
        stall_at_grant = s_stall;
      end
    end
    check("burst_first_grant_cycle", first_grant, MAXB + 1);
    check("burst_stall_at_grant", stall_at_grant, 1);
    check("burst_stall_cnt", s_stall_cnt, 1);

    // Yield: immediate grant, sticky flag.
    do_reset();
    step(mk(1, 0, 9'h010, 1, 0, 9'h020, 1, 0));
    check("yield_grant", s_grant, 1);
    step(mk(1, 0, 9'h011, 0, 0, '0, 0, 0));
    check("yield_starve_set", s_starve, 1);
    step(mk(1, 0, 9'h012, 0, 0, '0, 0, 0));
    check("yield_starve_sticky", s_starve, 1);

    // Init sweep: SW owns the memory for 512 cycles.
    do_reset();
    for (int i = 0; i < 512; i++) step(mk(1, 0, 9'(i + 7), 1, 1, 9'(i), 0, 1));
    idle();
    check("sweep_grant_cycles", cnt_grant, 512);
    check("sweep_stall_cycles", cnt_stall, 512);
    check("sweep_stall_cnt", s_stall_cnt, 512);

    // Table of single-cycle vectors, each from a cleared burst count.
    do_reset();
    vt[0] = '{0,0,0,0,0,0, 9'h000, 9'h000, 0,0,0,0, 9'h000};
    vt[1] = '{1,0,0,0,0,0, 9'h033, 9'h000, 0,0,1,0, 9'h033};
    vt[2] = '{1,1,0,0,0,0, 9'h044, 9'h000, 0,0,1,1, 9'h044};
    vt[3] = '{0,0,1,1,0,0, 9'h000, 9'h1A0, 1,0,1,1, 9'h1A0};
    vt[4] = '{0,0,1,0,0,0, 9'h000, 9'h1A0, 1,0,1,0, 9'h1A0};
    vt[5] = '{1,0,1,0,0,0, 9'h055, 9'h066, 0,0,1,0, 9'h055};
    vt[6] = '{1,1,1,0,1,0, 9'h077, 9'h088, 1,1,1,0, 9'h088};
    vt[7] = '{1,0,1,1,0,1, 9'h099, 9'h0AA, 1,1,1,1, 9'h0AA};
    vt[8] = '{1,0,0,0,1,0, 9'h0BB, 9'h000, 0,0,1,0, 9'h0BB};
    vt[9] = '{0,0,0,0,0,1, 9'h000, 9'h000, 0,0,0,0, 9'h000};
    for (int k = 0; k < 10; k++) begin
      idle();
      step(mk(vt[k].hcs, vt[k].hwe, vt[k].hadd, vt[k].scs, vt[k].swe, vt[k].sadd,
              vt[k].syld, vt[k].srst));
      check($sformatf("vec%0d_grant", k), s_grant, vt[k].e_grant);
      check($sformatf("vec%0d_stall", k), s_stall, vt[k].e_stall);
      check($sformatf("vec%0d_mem_cs", k), s_cs, vt[k].e_cs);
      check($sformatf("vec%0d_mem_we", k), s_we, vt[k].e_we);
      if (vt[k].e_cs) check($sformatf("vec%0d_mem_add", k), s_add, vt[k].e_add);
    end
    repeat (2) idle();

    // Reset while a HW read is in flight: its data must never be delivered.
    do_reset();
    step(mk(1, 0, 9'h003, 0, 0, '0, 0, 0));
    @(negedge clk);
    rst_n = 1'b0;
    hw_req_cs = 1; sw_cs = 1; sw_reset = 1;
    #1;
    check("midrst_grant", grant, 0);
    check("midrst_mem_cs", mem_cs, 0);
    check("midrst_hw_rdat_vld", hw_rdat_vld, 0);
    check("midrst_hw_rdat", hw_rdat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    zero_inputs();
    model_reset();
    cnt_vld = 0;
    repeat (3) idle();
    check("midrst_vld_after", cnt_vld, 0);
    check("midrst_hw_rdat_after", hw_rdat, 0);

    // Randomized traffic with SW requests held until granted.
    do_reset();
    sw_pend = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!sw_pend && $urandom_range(0, 9) < 4) sw_pend = 1;
      st = mk($urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0, 9'($urandom_range(0, 15)),
              sw_pend, $urandom_range(0, 1) == 1, 9'($urandom_range(0, 15)),
              $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0);
      step(st);
      if (m_sw_won) sw_pend = 0;
    end
    repeat (2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
